// File: rtl/gmii_rx_frame_buffer_if.sv
// Interface bundle for gmii_rx_frame_buffer. It carries the GMII receive inputs,
// the frame read/release port, and the statistics outputs.
interface gmii_rx_frame_buffer_if #(
  parameter int ADDR_W = 11,
  parameter int SLOTS  = 4,
  parameter int SLOT_W = 2,
  parameter int CNT_W  = 16
);
  logic              rx_dv;
  logic              rx_er;
  logic [7:0]        rx_data;
  logic [SLOTS-1:0]  slot_valid;
  logic [SLOT_W-1:0] rd_slot;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [ADDR_W:0]   rd_len;
  logic              rd_err;
  logic              rd_trunc;
  logic              rd_release;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  modport slave (
    input  rx_dv, rx_er, rx_data, rd_slot, rd_addr, rd_release,
    output slot_valid, rd_data, rd_len, rd_err, rd_trunc, frame_cnt, drop_cnt
  );
  modport master (
    output rx_dv, rx_er, rx_data, rd_slot, rd_addr, rd_release,
    input  slot_valid, rd_data, rd_len, rd_err, rd_trunc, frame_cnt, drop_cnt
  );
endinterface

// File: rtl/gmii_rx_frame_buffer.sv
// GMII RX frame capture into a ring of SLOTS byte buffers.
// The reader accesses committed frames through a registered read port and releases them one at a time.
module gmii_rx_frame_buffer #(
  parameter int ADDR_W         = 11,
  parameter int SLOTS          = 4,
  parameter int SLOT_W         = 2,
  parameter int STRIP_PREAMBLE = 1,
  parameter int MIN_LEN        = 1,
  parameter int CNT_W          = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  gmii_rx_frame_buffer_if.slave   bus
);
  localparam int DEPTH = SLOTS << ADDR_W;
  localparam logic [ADDR_W:0] MIN_L = (ADDR_W+1)'(MIN_LEN);
  localparam bit STRIP = (STRIP_PREAMBLE != 0);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
  state_t state, state_nxt;

  logic [SLOT_W-1:0]             wr_slot;
  logic [ADDR_W:0]               wr_ptr;
  logic                          err, trunc;
  logic [SLOTS-1:0]              slot_valid;
  logic [SLOTS-1:0][ADDR_W:0]    slot_len;
  logic [SLOTS-1:0]              slot_err, slot_trunc;
  logic [7:0]                    mem [DEPTH];
  logic [CNT_W-1:0]              frame_cnt, drop_cnt;
  logic [7:0]                    rd_data;
  logic [ADDR_W:0]               rd_len;
  logic                          rd_err, rd_trunc;

  logic slot_free, is_pre, is_sfd, full;
  logic enter_data, store, commit, drop_inc;
  logic [SLOT_W+ADDR_W-1:0] wa;

  assign slot_free = !slot_valid[wr_slot];
  assign is_pre    = (bus.rx_data == 8'h55);
  assign is_sfd    = (bus.rx_data == 8'hD5);
  // wr_ptr's top bit set means the slot is exactly full
  assign full      = wr_ptr[ADDR_W];

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (bus.rx_dv) begin
          if (!STRIP)      state_nxt = slot_free ? DATA : DROP;
          else if (is_pre) state_nxt = PRE;
          else if (is_sfd) state_nxt = slot_free ? DATA : DROP;
          else             state_nxt = DROP;
        end
      PRE:
        if (!bus.rx_dv)  state_nxt = IDLE;
        else if (is_pre) state_nxt = PRE;
        else if (is_sfd) state_nxt = slot_free ? DATA : DROP;
        else             state_nxt = DROP;
      DATA: if (!bus.rx_dv) state_nxt = IDLE;
      DROP: if (!bus.rx_dv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    enter_data = (state == IDLE || state == PRE) && state_nxt == DATA;
    store      = 1'b0;
    commit     = 1'b0;
    drop_inc   = 1'b0;
    unique case (state)
      IDLE: drop_inc = (state_nxt == DROP);
      PRE:  drop_inc = (state_nxt == DROP) || !bus.rx_dv;
      DATA:
        if (bus.rx_dv)            store    = !full;
        else if (wr_ptr >= MIN_L) commit   = 1'b1;
        else                      drop_inc = 1'b1;
      default: ;
    endcase
    // without stripping, the byte that opens the frame is payload byte 0
    if (enter_data && !STRIP) store = 1'b1;
  end

  assign wa = {wr_slot, enter_data ? {ADDR_W{1'b0}} : wr_ptr[ADDR_W-1:0]};

  always_ff @(posedge clock)
    if (store) mem[wa] <= bus.rx_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_slot    <= '0;
      wr_ptr     <= '0;
      err        <= 1'b0;
      trunc      <= 1'b0;
      slot_len   <= '0;
      slot_err   <= '0;
      slot_trunc <= '0;
    end else begin
      if (enter_data) begin
        wr_ptr <= STRIP ? '0 : (ADDR_W+1)'(1);
        err    <= !STRIP && bus.rx_er;
        trunc  <= 1'b0;
      end else if (state == DATA && bus.rx_dv) begin
        if (full) trunc  <= 1'b1;
        else      wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
        if (bus.rx_er) err <= 1'b1;
      end
      if (commit) begin
        slot_len[wr_slot]   <= wr_ptr;
        slot_err[wr_slot]   <= err;
        slot_trunc[wr_slot] <= trunc;
        wr_slot             <= wr_slot + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) slot_valid <= '0;
    else
      for (int i = 0; i < SLOTS; i++) begin
        if (commit && wr_slot == SLOT_W'(i))                  slot_valid[i] <= 1'b1;
        else if (bus.rd_release && bus.rd_slot == SLOT_W'(i)) slot_valid[i] <= 1'b0;
      end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (commit   && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
      if (drop_inc && drop_cnt  != '1) drop_cnt  <= drop_cnt  + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_len   <= '0;
      rd_err   <= 1'b0;
      rd_trunc <= 1'b0;
    end else begin
      rd_data  <= mem[{bus.rd_slot, bus.rd_addr}];
      rd_len   <= slot_len[bus.rd_slot];
      rd_err   <= slot_err[bus.rd_slot];
      rd_trunc <= slot_trunc[bus.rd_slot];
    end
  end

  assign bus.slot_valid = slot_valid;
  assign bus.rd_data    = rd_data;
  assign bus.rd_len     = rd_len;
  assign bus.rd_err     = rd_err;
  assign bus.rd_trunc   = rd_trunc;
  assign bus.frame_cnt  = frame_cnt;
  assign bus.drop_cnt   = drop_cnt;
endmodule
